// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants and types for the ID/EX stage.
// Optional feature macro used by this slice: ID_WB_BYPASS_EN (regfile write-through).
package id_ex_stage_pkg;

  localparam int unsigned XLEN = 32;

  // RV32I major opcodes handled by the decoder
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU function codes: bit3 = negate/arith, bits[2:0] = funct3
  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SLL  = 4'b0001;
  localparam logic [3:0] FN_SLT  = 4'b0010;
  localparam logic [3:0] FN_SLTU = 4'b0011;
  localparam logic [3:0] FN_XOR  = 4'b0100;
  localparam logic [3:0] FN_SRL  = 4'b0101;
  localparam logic [3:0] FN_OR   = 4'b0110;
  localparam logic [3:0] FN_AND  = 4'b0111;
  localparam logic [3:0] FN_SUB  = 4'b1000;
  localparam logic [3:0] FN_SRA  = 4'b1101;

  localparam logic [2:0] F3_SR   = 3'b101;

  // Payload carried from ID into EX
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] lhs;
    logic [XLEN-1:0] rhs;
    logic [3:0]      funct;
    logic [4:0]      rd;
    logic            rf_we;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } id_ex_t;

  // Sign-extend a 12-bit I-type immediate
  function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

  // Place a 20-bit U-type immediate in the upper bits
  function automatic logic [XLEN-1:0] uimm(input logic [19:0] imm);
    return {imm, 12'b0};
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: 32 x XLEN, two combinational read ports,
// one write port, synchronous active-high reset, x0 hardwired to zero.
// ID_WB_BYPASS_EN: when defined, a read of the register being written in the
// same cycle returns the incoming write data instead of the stored value.
module id_regfile
  import id_ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs [32];

  // Clear all registers on reset; otherwise write any register except x0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (rd_addr != 5'd0)) begin
      regs[rd_addr] <= wr_data;
    end
  end

  // Combinational reads with x0 forced to zero and optional write-through
  always_comb begin
    rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
`ifdef ID_WB_BYPASS_EN
    if (we && (rd_addr != 5'd0) && (rd_addr == rs1_addr)) begin
      rs1_data = wr_data;
    end
    if (we && (rd_addr != 5'd0) && (rd_addr == rs2_addr)) begin
      rs2_data = wr_data;
    end
`endif
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register for an RV32I integer pipe.
// Decodes OP, OP-IMM, LUI and AUIPC into ALU operands, funct code and
// writeback control; anything else is flagged illegal.
// Optional feature macro: ID_WB_BYPASS_EN (regfile write-through, in id_regfile).
module id_ex_stage #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_lhs,
  output logic [XLEN-1:0] ex_rhs,
  output logic [3:0]      ex_funct,
  output logic [4:0]      ex_rd,
  output logic            ex_rf_we,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal
);

  import id_ex_stage_pkg::*;

  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  id_ex_t          dec;
  id_ex_t          ex_q;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign funct3 = if_instr[14:12];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];

  assign id_ready = !stall;

  id_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (wb_we),
    .rd_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  // Decode the presented instruction into the EX payload
  always_comb begin
    dec         = '0;
    dec.valid   = if_valid;
    dec.rd      = rd;
    dec.pc      = if_pc;
    dec.funct   = FN_ADD;
    unique case (opcode)
      OPC_OP: begin
        dec.lhs   = rs1_data;
        dec.rhs   = rs2_data;
        dec.funct = {if_instr[30], funct3};
        dec.rf_we = if_valid && (rd != 5'd0);
      end
      OPC_OP_IMM: begin
        // instr[30] is immediate data except for SRAI, so ADDI never subtracts
        dec.lhs   = rs1_data;
        dec.rhs   = sext12(if_instr[31:20]);
        dec.funct = {(funct3 == F3_SR) && if_instr[30], funct3};
        dec.rf_we = if_valid && (rd != 5'd0);
      end
      OPC_LUI: begin
        dec.lhs   = '0;
        dec.rhs   = uimm(if_instr[31:12]);
        dec.rf_we = if_valid && (rd != 5'd0);
      end
      OPC_AUIPC: begin
        dec.lhs   = if_pc;
        dec.rhs   = uimm(if_instr[31:12]);
        dec.rf_we = if_valid && (rd != 5'd0);
      end
      default: begin
        // bubbles carry no exception, only real instructions can be illegal
        dec.illegal = if_valid;
        dec.rf_we   = 1'b0;
      end
    endcase
  end

  // ID/EX register: reset > flush > stall > capture
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      ex_q.pc <= RESET_PC;
    end else if (flush) begin
      ex_q         <= dec;
      ex_q.valid   <= 1'b0;
      ex_q.rf_we   <= 1'b0;
      ex_q.illegal <= 1'b0;
    end else if (!stall) begin
      ex_q <= dec;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_lhs     = ex_q.lhs;
  assign ex_rhs     = ex_q.rhs;
  assign ex_funct   = ex_q.funct;
  assign ex_rd      = ex_q.rd;
  assign ex_rf_we   = ex_q.rf_we;
  assign ex_pc      = ex_q.pc;
  assign ex_illegal = ex_q.illegal;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register that feeds the execute-stage ALU.
- Takes a fetched RV32I instruction and reads the register file.
- Produces the ALU operands lhs/rhs, the 4-bit ALU funct code, and writeback control.
- Registers all of these for the EX stage.
- Owns the architectural register file; the WB stage writes it.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0000_0000, value driven on ex_pc after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  32  PC of if_instr.
- id_ready  out  1  stage accepts if_instr this cycle.
- stall  in  1  hazard unit holds the ID/EX register.
- flush  in  1  branch/redirect squashes the instruction being captured.
- wb_we  in  1  register-file write enable.
- wb_rd  in  5  write index.
- wb_data  in  32  write data.
- ex_valid  out  1  EX-stage payload valid.
- ex_lhs  out  32  ALU left operand.
- ex_rhs  out  32  ALU right operand.
- ex_funct  out  4  ALU function: bit3 = negate/arith, bits[2:0] = funct3.
- ex_rd  out  5  destination register.
- ex_rf_we  out  1  EX result is to be written back.
- ex_pc  out  32  PC of the EX instruction.
- ex_illegal  out  1  unsupported opcode was captured.

Behaviour:
- **Reset** (synchronous, on clk edge with reset=1):
  - ex_valid, ex_rf_we and ex_illegal = 0.
  - ex_lhs, ex_rhs, ex_funct and ex_rd = 0.
  - ex_pc = RESET_PC.
  - All 32 registers = 0.
  - reset overrides stall, flush and wb_we.
- **Handshake:** id_ready = !stall (combinational). An instruction is consumed on a cycle with if_valid && id_ready.
- **ID/EX register update:**
  - stall=1 and flush=0: all ex_* hold their values.
  - flush=1: ex_valid=0, ex_rf_we=0, ex_illegal=0; other fields don't-care. Flush wins over stall.
  - Otherwise: capture the decode of if_instr, with ex_valid = if_valid.
  - Latency is one cycle from instruction presentation to ex_* outputs.
- **Decode table** (rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7]):
  - OP (0110011): lhs=R[rs1], rhs=R[rs2], funct = {instr[30], instr[14:12]}.
  - OP-IMM (0010011): lhs=R[rs1], rhs=sext(instr[31:20]).
    - funct[2:0] = instr[14:12].
    - funct[3] = instr[30] only when funct3=101 (SRAI); otherwise 0. ADDI must never subtract.
  - LUI (0110111): lhs=0, rhs={instr[31:12], 12'b0}, funct=0000.
  - AUIPC (0010111): lhs=if_pc, rhs={instr[31:12], 12'b0}, funct=0000.
  - All four types: ex_rf_we = (rd != 0).
  - Any other opcode: ex_illegal=1, ex_rf_we=0, funct=0000.
- **Register file:**
  - 32x32; x0 reads 0 and writes to x0 are ignored.
  - Write happens on the clk edge when wb_we=1, including during stall and flush.
  - Reads are combinational.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: a read of rs (rs != 0) in the same cycle as wb_we with wb_rd == rs returns wb_data (write-through).
- Undefined: the read returns the pre-write value. The hazard unit must then stall one extra cycle; id_ex_stage itself does not change behaviour otherwise.

Decomposition:
- Shared package holds:
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC;
  - ALU funct constants (FN_ADD=0000, FN_SUB=1000, FN_SLL, FN_SLT, FN_SLTU, FN_XOR, FN_SRL, FN_SRA=1101, FN_OR, FN_AND);
  - XLEN.
- One sub-module, id_regfile: 2 read ports, 1 write port, synchronous reset, and the bypass under the macro.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093), no stall → next cycle: ex_valid=1, lhs=0, rhs=0xFFFFFFFB, funct=0000, rd=1, ex_rf_we=1.
- SUB x3,x1,x2 (0x402081B3) with R1=10, R2=3 → funct=1000, lhs=10, rhs=3. SRAI x4,x1,2 (0x4020D213) → funct=1101, rhs=0x402.
- stall=1 for 3 cycles, then stall=1 and flush=1 together → ex_* hold for 3 cycles, then ex_valid=0 and ex_rf_we=0; id_ready=0 throughout.
- wb_we=1, wb_rd=5, wb_data=0x1234 in the same cycle as ADD x6,x5,x0 → lhs=0x1234 with ID_WB_BYPASS_EN defined; lhs=old R5 (0) without it.
- Write wb_rd=0, wb_data=0xFFFF_FFFF, then ADD x7,x0,x0 → lhs=rhs=0. AUIPC x8,1 at pc=0x100 → lhs=0x100, rhs=0x1000.
- reset asserted mid-stream after R9=7 → ex_valid=0 and ex_pc=RESET_PC next cycle. A subsequent read of x9 returns 0. Opcode 0x0000007F → ex_illegal=1, ex_rf_we=0.
